// File: rtl/tone_pkg.sv
// Shared constants and types for the tone decoder: counter width, nominal
// note half-periods (matching the buzzer), and the half-period classifier.
package tone_pkg;

  localparam int unsigned CNT_W     = 20;
  localparam int unsigned NUM_NOTES = 7;

  typedef logic [3:0]       note_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    SILENT  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Half-periods in clk cycles for do..si; shared with the buzzer.
  localparam int unsigned NOM_HALF [1:7] = '{
    381681, 340137, 303031, 285715, 255103, 227274, 202430
  };

  // Returns the note whose window |h - nom| <= tol contains h, else 0.
  // The nominal table can be scaled down by 2^shift for fast simulation.
  function automatic note_t classify(input int unsigned h,
                                     input int unsigned tol,
                                     input int unsigned shift);
    note_t k;
    k = '0;
    for (int i = 1; i <= int'(NUM_NOTES); i++) begin
      int unsigned nom;
      int unsigned diff;
      nom  = NOM_HALF[i] >> shift;
      diff = (h >= nom) ? (h - nom) : (nom - h);
      if (diff <= tol) k = note_t'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/tone_edge_detect.sv
// Synchronises the asynchronous tone and emits a one-cycle pulse on each level change.
// Optional 4-sample stability filter when TONE_DECODER_GLITCH_FILTER_EN is defined.
module tone_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic tone_in,
  output logic tone_edge
);

  logic sync1_q, sync2_q;
  logic lvl;
  logic lvl_dly_q;

  // NOTE: sequential state is always written with non-blocking (<=) so every
  // flop samples the pre-edge value of its neighbours, giving a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef TONE_DECODER_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [1:0] run_q, run_d;

  // The filtered level follows sync2 only after 4 consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    run_d  = 2'd0;
    if (sync2_q != filt_q) begin
      if (run_q == 2'd3) filt_d = sync2_q;
      else               run_d  = run_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      run_q  <= 2'd0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_dly_q <= 1'b0;
    else        lvl_dly_q <= lvl;
  end

  assign tone_edge = lvl ^ lvl_dly_q;

endmodule

// File: rtl/tone_decoder.sv
// Measures the half-period of a square-wave tone and locks onto note 1..7.
// Build option TONE_DECODER_GLITCH_FILTER_EN adds an input stability filter.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int unsigned TOL       = 4096,
  parameter int unsigned MATCH_CNT = 2,
  parameter int unsigned TIMEOUT   = 800000,
  parameter int unsigned NOM_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tone_in,
  output logic [3:0] note,
  output logic       locked,
  output logic       note_change
);

  localparam cnt_t CNT_MAX = '1;

  logic       tone_edge;
  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  note_t      cand_q, cand_d;
  logic [2:0] streak_q, streak_d;
  logic [2:0] streak_next;
  note_t      note_q, note_d;
  logic       locked_q, locked_d;
  logic       chg_q, chg_d;
  note_t      k;
  logic       timeout;

  tone_edge_detect u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .tone_in   (tone_in),
    .tone_edge (tone_edge)
  );

  // The counter value at an edge is the edge-to-edge distance H.
  assign k       = classify(32'(cnt_q), TOL, NOM_SHIFT);
  assign timeout = (32'(cnt_q) >= TIMEOUT);

  always_comb begin
    cnt_d = cnt_q;
    if (tone_edge)             cnt_d = cnt_t'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + cnt_t'(1);
  end

  // NOTE: every signal assigned here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    streak_d    = streak_q;
    note_d      = note_q;
    locked_d    = locked_q;
    chg_d       = 1'b0;
    streak_next = (k == cand_q) ? (streak_q + 3'd1) : 3'd1;

    unique case (state_q)
      SILENT: begin
        if (tone_edge) begin
          state_d  = MEASURE;
          cand_d   = '0;
          streak_d = '0;
        end
      end

      MEASURE: begin
        if (tone_edge) begin
          if (k == '0) begin
            cand_d   = '0;
            streak_d = '0;
          end else begin
            cand_d   = k;
            streak_d = streak_next;
            if (32'(streak_next) >= MATCH_CNT) begin
              state_d  = LOCKED;
              note_d   = k;
              locked_d = 1'b1;
              chg_d    = (k != note_q);
            end
          end
        end else if (timeout) begin
          state_d  = SILENT;
          cand_d   = '0;
          streak_d = '0;
          note_d   = '0;
          locked_d = 1'b0;
          chg_d    = (note_q != '0);
        end
      end

      LOCKED: begin
        if (tone_edge) begin
          if (k != note_q) begin
            if (k != '0 && MATCH_CNT == 1) begin
              // A single valid period is already a full match.
              cand_d   = k;
              streak_d = 3'd1;
              note_d   = k;
              chg_d    = 1'b1;
            end else begin
              state_d  = MEASURE;
              cand_d   = k;
              streak_d = (k != '0) ? 3'd1 : 3'd0;
              locked_d = 1'b0;
            end
          end
        end else if (timeout) begin
          state_d  = SILENT;
          cand_d   = '0;
          streak_d = '0;
          note_d   = '0;
          locked_d = 1'b0;
          chg_d    = (note_q != '0);
        end
      end

      default: begin
        state_d  = SILENT;
        note_d   = '0;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SILENT;
      cnt_q    <= '0;
      cand_q   <= '0;
      streak_q <= '0;
      note_q   <= '0;
      locked_q <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      streak_q <= streak_d;
      note_q   <= note_d;
      locked_q <= locked_d;
      chg_q    <= chg_d;
    end
  end

  assign note        = note_q;
  assign locked      = locked_q;
  assign note_change = chg_q;

endmodule
